ram1_responder: RTL

//   Memory-side responder for the processor's RAM1 data-memory interface. Accepts word-addressed

---
 rtl/ram1_responder.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/ram1_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ram1_responder : RAM1 data-memory responder, four-phase MFC handshake with   |
// |                  wait states. Optional macro RAM1_ACCESS_COUNT_EN adds        |
// |                  read/write access counters.                                  |
// | Revision       : 1.0                                                         |
// +----------------------------------------------------------------------------+
module ram1_responder #(
    parameter int DEPTH       = 256,
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        RAM1_Request,
    input  logic        RAM1_Read_H_Write_L,
    input  logic [31:0] RAM1_Address,
    input  logic [31:0] RAM1_Data_In,
    output logic [31:0] RAM1_Data_Out,
    output logic        RAM1_MFC,
    output logic        RAM1_Out_Enable,
    output logic        RAM1_Addr_Error
`ifdef RAM1_ACCESS_COUNT_EN
    ,
    output logic [15:0] RAM1_Read_Count,
    output logic [15:0] RAM1_Write_Count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    localparam logic [3:0]  C_WAIT_LOAD = 4'(WAIT_CYCLES);
    localparam logic [31:0] C_DEPTH     = 32'(DEPTH);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [3:0]             r_cnt;
    logic [31:0]            r_addr;
    logic [31:0]            r_data;
    logic                   r_read;
    logic                   w_ack_entry;
    logic                   w_out_of_range;
    logic [ADDR_BITS-1:0]   w_index;
    logic [31:0]            r_mem [DEPTH];

    assign w_out_of_range = (r_addr >= C_DEPTH);
    assign w_index        = r_addr[ADDR_BITS-1:0];

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Every access passes through WAIT and leaves it when the counter has run
    // down to zero, which places MFC exactly WAIT_CYCLES+1 edges after capture.
    always_comb begin
        w_state_next = r_state;
        w_ack_entry  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (RAM1_Request) begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!RAM1_Request) begin
                    w_state_next = ST_IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_state_next = ST_ACK;
                    w_ack_entry  = 1'b1;
                end
            end
            ST_ACK: begin
                if (!RAM1_Request) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_cnt           <= 4'd0;
            r_addr          <= 32'd0;
            r_data          <= 32'd0;
            r_read          <= 1'b0;
            RAM1_Data_Out   <= 32'd0;
            RAM1_MFC        <= 1'b0;
            RAM1_Out_Enable <= 1'b0;
            RAM1_Addr_Error <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && RAM1_Request) begin
                r_addr <= RAM1_Address;
                r_data <= RAM1_Data_In;
                r_read <= RAM1_Read_H_Write_L;
                r_cnt  <= C_WAIT_LOAD;
            end else if (r_state == ST_WAIT && RAM1_Request && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (w_ack_entry) begin
                RAM1_MFC        <= 1'b1;
                RAM1_Addr_Error <= w_out_of_range;
                if (r_read) begin
                    RAM1_Out_Enable <= 1'b1;
                    RAM1_Data_Out   <= w_out_of_range ? 32'd0 : r_mem[w_index];
                end
            end else if (r_state == ST_ACK && !RAM1_Request) begin
                RAM1_MFC        <= 1'b0;
                RAM1_Out_Enable <= 1'b0;
                RAM1_Addr_Error <= 1'b0;
            end
        end
    end

    // Array has no reset so its contents survive Reset.
    always_ff @(posedge Clock) begin
        if (w_ack_entry && !r_read && !w_out_of_range) begin
            r_mem[w_index] <= r_data;
        end
    end

`ifdef RAM1_ACCESS_COUNT_EN
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            RAM1_Read_Count  <= 16'd0;
            RAM1_Write_Count <= 16'd0;
        end else if (w_ack_entry) begin
            if (r_read) begin
                RAM1_Read_Count <= RAM1_Read_Count + 16'd1;
            end else begin
                RAM1_Write_Count <= RAM1_Write_Count + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire
